// File: rtl/control_field_gen_if.sv
// Control-field serializer bus: frame descriptor and strobes in,
// serial bit, progress and decoded payload length out.
interface control_field_gen_if #(
   parameter int BYTE_CNT_WIDTH = 7
);
   logic                      enable;
   logic                      sample_point;
   logic                      Tx_request;
   logic                      rtr_complete;
   logic                      ide;
   logic                      rtr;
   logic                      fdf;
   logic                      brs;
   logic                      esi;
   logic [3:0]                dlc;
   logic                      control_bit;
   logic [3:0]                bit_counter;
   logic                      control_complete;
   logic                      brs_switch;
   logic [BYTE_CNT_WIDTH-1:0] data_bytes;
   logic                      busy;

   // Frame controller side
   modport master (
      output enable, sample_point, Tx_request, rtr_complete,
      output ide, rtr, fdf, brs, esi, dlc,
      input  control_bit, bit_counter, control_complete, brs_switch,
      input  data_bytes, busy
   );

   // Serializer side
   modport slave (
      input  enable, sample_point, Tx_request, rtr_complete,
      input  ide, rtr, fdf, brs, esi, dlc,
      output control_bit, bit_counter, control_complete, brs_switch,
      output data_bytes, busy
   );
endinterface

// File: rtl/control_field_gen.sv
// CAN control-field serializer for classic/FD, base/extended frames.
// Emits the field MSB-first one bit per sample_point after arbitration,
// decodes DLC into a payload byte count and flags the bit-rate switch.
module control_field_gen #(
   parameter int FD_SUPPORT     = 1,
   parameter int BYTE_CNT_WIDTH = 7
) (
   input  logic                 clock,
   input  logic                 reset_n,
   control_field_gen_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFT    = 2'd1,
      COMPLETE = 2'd2
   } state_t;

   state_t                    state;

   // Registered outputs
   logic                      control_bit_q;
   logic [3:0]                bit_counter_q;
   logic                      complete_q;
   logic                      brs_switch_q;
   logic [BYTE_CNT_WIDTH-1:0] data_bytes_q;
   logic                      busy_q;

   // Frame descriptor captured on the start cycle
   logic [8:0]                field_q;      // bit i of the field sits at field_q[i]
   logic [3:0]                last_idx_q;   // index of the final field bit
   logic [3:0]                brs_idx_q;    // index of the BRS bit
   logic                      brs_arm_q;    // FD frame with BRS=1

   // Decode of the live inputs, used only on the start cycle
   logic                      start;
   logic                      fd_eff;
   logic [8:0]                field_next;
   logic [3:0]                last_idx_next;
   logic [3:0]                brs_idx_next;
   logic [6:0]                bytes_raw;
   logic [BYTE_CNT_WIDTH-1:0] bytes_next;
   logic [3:0]                next_idx;
   logic                      keep_going;

   assign start      = bus.enable & bus.Tx_request & bus.rtr_complete;
   assign keep_going = bus.enable & bus.Tx_request;
   assign next_idx   = bit_counter_q + 4'd1;

   // Build the field image and its length for the frame format on the inputs
   always_comb begin
      fd_eff        = (FD_SUPPORT != 0) && bus.fdf && !bus.rtr;
      field_next    = '0;
      last_idx_next = 4'd5;
      brs_idx_next  = 4'd3;
      if (fd_eff && !bus.ide) begin
         // IDE=0, FDF=1, res=0, BRS, ESI, DLC[3:0]
         field_next    = {bus.dlc[0], bus.dlc[1], bus.dlc[2], bus.dlc[3],
                          bus.esi, bus.brs, 1'b0, 1'b1, 1'b0};
         last_idx_next = 4'd8;
         brs_idx_next  = 4'd3;
      end else if (fd_eff) begin
         // FDF=1, res=0, BRS, ESI, DLC[3:0]
         field_next    = {1'b0, bus.dlc[0], bus.dlc[1], bus.dlc[2], bus.dlc[3],
                          bus.esi, bus.brs, 1'b0, 1'b1};
         last_idx_next = 4'd7;
         brs_idx_next  = 4'd2;
      end else begin
         // IDE/r1=0, r0=0, DLC[3:0]; base and extended share the image
         field_next    = {3'b000, bus.dlc[0], bus.dlc[1], bus.dlc[2], bus.dlc[3],
                          2'b00};
         last_idx_next = 4'd5;
         brs_idx_next  = 4'd3;
      end
   end

   // Translate DLC into the payload byte count for the data-field block
   always_comb begin
      bytes_raw = '0;
      if (bus.rtr) begin
         bytes_raw = '0;
      end else if (fd_eff) begin
         case (bus.dlc)
            4'd9:    bytes_raw = 7'd12;
            4'd10:   bytes_raw = 7'd16;
            4'd11:   bytes_raw = 7'd20;
            4'd12:   bytes_raw = 7'd24;
            4'd13:   bytes_raw = 7'd32;
            4'd14:   bytes_raw = 7'd48;
            4'd15:   bytes_raw = 7'd64;
            default: bytes_raw = {3'b000, bus.dlc};
         endcase
      end else if (bus.dlc > 4'd8) begin
         bytes_raw = 7'd8;
      end else begin
         bytes_raw = {3'b000, bus.dlc};
      end
      bytes_next = BYTE_CNT_WIDTH'(bytes_raw);
   end

   // Sequencer: start capture, bit shifting on strobes, completion hold, abort
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         control_bit_q <= 1'b1;
         bit_counter_q <= '0;
         complete_q    <= 1'b0;
         brs_switch_q  <= 1'b0;
         data_bytes_q  <= '0;
         busy_q        <= 1'b0;
         field_q       <= '0;
         last_idx_q    <= '0;
         brs_idx_q     <= '0;
         brs_arm_q     <= 1'b0;
      end else begin
         brs_switch_q <= 1'b0;
         case (state)
            IDLE: begin
               control_bit_q <= 1'b1;
               bit_counter_q <= '0;
               complete_q    <= 1'b0;
               busy_q        <= 1'b0;
               data_bytes_q  <= '0;
               if (start) begin
                  state         <= SHIFT;
                  field_q       <= field_next;
                  last_idx_q    <= last_idx_next;
                  brs_idx_q     <= brs_idx_next;
                  brs_arm_q     <= fd_eff & bus.brs;
                  control_bit_q <= field_next[0];
                  busy_q        <= 1'b1;
                  data_bytes_q  <= bytes_next;
               end
            end

            SHIFT: begin
               if (!keep_going) begin
                  state         <= IDLE;
                  control_bit_q <= 1'b1;
                  bit_counter_q <= '0;
                  complete_q    <= 1'b0;
                  busy_q        <= 1'b0;
                  data_bytes_q  <= '0;
               end else if (bus.sample_point) begin
                  // BRS is never the last bit, so the pulse cannot collide with completion
                  if (brs_arm_q && (bit_counter_q == brs_idx_q)) begin
                     brs_switch_q <= 1'b1;
                  end
                  if (bit_counter_q == last_idx_q) begin
                     state         <= COMPLETE;
                     complete_q    <= 1'b1;
                     busy_q        <= 1'b0;
                     control_bit_q <= 1'b1;
                  end else begin
                     bit_counter_q <= next_idx;
                     control_bit_q <= field_q[next_idx];
                  end
               end
            end

            COMPLETE: begin
               if (!keep_going) begin
                  state         <= IDLE;
                  control_bit_q <= 1'b1;
                  bit_counter_q <= '0;
                  complete_q    <= 1'b0;
                  busy_q        <= 1'b0;
                  data_bytes_q  <= '0;
               end
            end

            default: begin
               state         <= IDLE;
               control_bit_q <= 1'b1;
               bit_counter_q <= '0;
               complete_q    <= 1'b0;
               busy_q        <= 1'b0;
               data_bytes_q  <= '0;
            end
         endcase
      end
   end

   assign bus.control_bit      = control_bit_q;
   assign bus.bit_counter      = bit_counter_q;
   assign bus.control_complete = complete_q;
   assign bus.brs_switch       = brs_switch_q;
   assign bus.data_bytes       = data_bytes_q;
   assign bus.busy             = busy_q;

endmodule

// File: tb/tb_control_field_gen.sv
// Bench for control_field_gen: an FD-capable and a classic-only instance
// share one stimulus; the selected instance is compared against expectations.
module tb_control_field_gen;

   logic       clock;
   logic       reset_n;
   logic       enable, sample_point, tx_request, rtr_complete;
   logic       ide, rtr, fdf, brs, esi;
   logic [3:0] dlc;

   int n_checks = 0;
   int n_errors = 0;
   int frame_no = 0;
   logic dut_sel = 1'b0;   // 0: FD_SUPPORT=1 instance, 1: FD_SUPPORT=0 instance

   control_field_gen_if #(.BYTE_CNT_WIDTH(7)) bus_fd ();
   control_field_gen_if #(.BYTE_CNT_WIDTH(4)) bus_cl ();

   assign bus_fd.enable       = enable;
   assign bus_fd.sample_point = sample_point;
   assign bus_fd.Tx_request   = tx_request;
   assign bus_fd.rtr_complete = rtr_complete;
   assign bus_fd.ide          = ide;
   assign bus_fd.rtr          = rtr;
   assign bus_fd.fdf          = fdf;
   assign bus_fd.brs          = brs;
   assign bus_fd.esi          = esi;
   assign bus_fd.dlc          = dlc;

   assign bus_cl.enable       = enable;
   assign bus_cl.sample_point = sample_point;
   assign bus_cl.Tx_request   = tx_request;
   assign bus_cl.rtr_complete = rtr_complete;
   assign bus_cl.ide          = ide;
   assign bus_cl.rtr          = rtr;
   assign bus_cl.fdf          = fdf;
   assign bus_cl.brs          = brs;
   assign bus_cl.esi          = esi;
   assign bus_cl.dlc          = dlc;

   control_field_gen #(.FD_SUPPORT(1), .BYTE_CNT_WIDTH(7)) dut_fd (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus_fd)
   );

   control_field_gen #(.FD_SUPPORT(0), .BYTE_CNT_WIDTH(4)) dut_cl (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus_cl)
   );

   logic       o_bit, o_complete, o_brs, o_busy;
   logic [3:0] o_cnt;
   logic [6:0] o_bytes;

   // Route the selected instance to the comparison signals
   always_comb begin
      if (dut_sel) begin
         o_bit      = bus_cl.control_bit;
         o_cnt      = bus_cl.bit_counter;
         o_complete = bus_cl.control_complete;
         o_brs      = bus_cl.brs_switch;
         o_bytes    = {3'b000, bus_cl.data_bytes};
         o_busy     = bus_cl.busy;
      end else begin
         o_bit      = bus_fd.control_bit;
         o_cnt      = bus_fd.bit_counter;
         o_complete = bus_fd.control_complete;
         o_brs      = bus_fd.brs_switch;
         o_bytes    = bus_fd.data_bytes;
         o_busy     = bus_fd.busy;
      end
   end

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, " idle bit"},      32'(o_bit),      32'd1);
      check({tag, " idle cnt"},      32'(o_cnt),      32'd0);
      check({tag, " idle complete"}, 32'(o_complete), 32'd0);
      check({tag, " idle brs"},      32'(o_brs),      32'd0);
      check({tag, " idle bytes"},    32'(o_bytes),    32'd0);
      check({tag, " idle busy"},     32'(o_busy),     32'd0);
   endtask

   // Reference: assemble the field from the frame-format rules
   task automatic model(input logic fd_sup, input logic m_ide, input logic m_rtr,
                        input logic m_fdf, input logic m_brs, input logic m_esi,
                        input logic [3:0] m_dlc, output int len, output logic [8:0] vec,
                        output int bytes, output int brs_at);
      bit q[$];
      bit fd;
      int fd_len [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 12, 16, 20, 24, 32, 48, 64};
      fd = fd_sup && m_fdf && !m_rtr;
      brs_at = -1;
      if (!m_ide) q.push_back(1'b0);           // IDE
      if (fd) begin
         q.push_back(1'b1);                     // FDF
         q.push_back(1'b0);                     // res
         if (m_brs) brs_at = q.size();
         q.push_back(m_brs);
         q.push_back(m_esi);
      end else begin
         if (m_ide) q.push_back(1'b0);          // r1
         q.push_back(1'b0);                     // r0
      end
      for (int k = 3; k >= 0; k--) q.push_back(m_dlc[k]);
      len = q.size();
      vec = '0;
      for (int k = 0; k < len; k++) vec[8-k] = q[k];
      if (m_rtr)    bytes = 0;
      else if (fd)  bytes = fd_len[m_dlc];
      else          bytes = (m_dlc > 8) ? 8 : int'(m_dlc);
   endtask

   // One full field: start, len strobes with random gaps, hold, release.
   // bits holds field bit i at position 8-i.
   task automatic run_frame(input logic s, input logic f_ide, input logic f_rtr,
                            input logic f_fdf, input logic f_brs, input logic f_esi,
                            input logic [3:0] f_dlc, input int len, input logic [8:0] bits,
                            input int bytes, input int brs_at, input bit scramble);
      string tag;
      int gap;
      frame_no++;
      tag = $sformatf("f%0d", frame_no);
      dut_sel = s;
      ide = f_ide; rtr = f_rtr; fdf = f_fdf; brs = f_brs; esi = f_esi; dlc = f_dlc;
      enable = 1'b1; tx_request = 1'b1; rtr_complete = 1'b1;
      sample_point = 1'($urandom_range(0, 1));   // ignored on the start cycle
      tick();
      rtr_complete = 1'b0;
      sample_point = 1'b0;
      check({tag, " start bit"},   32'(o_bit),      32'(bits[8]));
      check({tag, " start cnt"},   32'(o_cnt),      32'd0);
      check({tag, " start busy"},  32'(o_busy),     32'd1);
      check({tag, " start bytes"}, 32'(o_bytes),    32'(bytes));
      check({tag, " start cmpl"},  32'(o_complete), 32'd0);
      for (int i = 0; i < len; i++) begin
         gap = $urandom_range(0, 2);
         if (gap != 0) sample_point = 1'b0;
         for (int g = 0; g < gap; g++) begin
            if (scramble) begin
               ide = 1'($urandom); rtr = 1'($urandom); fdf = 1'($urandom);
               brs = 1'($urandom); esi = 1'($urandom); dlc = 4'($urandom);
               rtr_complete = 1'($urandom);
            end
            tick();
            check($sformatf("%s gap%0d bit", tag, i), 32'(o_bit), 32'(bits[8-i]));
            check($sformatf("%s gap%0d cnt", tag, i), 32'(o_cnt), 32'(i));
            check($sformatf("%s gap%0d brs", tag, i), 32'(o_brs), 32'd0);
         end
         sample_point = 1'b1;
         tick();
         check($sformatf("%s sp%0d brs", tag, i), 32'(o_brs), (i == brs_at) ? 32'd1 : 32'd0);
         if (i < len - 1) begin
            check($sformatf("%s sp%0d bit", tag, i),  32'(o_bit),      32'(bits[8-(i+1)]));
            check($sformatf("%s sp%0d cnt", tag, i),  32'(o_cnt),      32'(i + 1));
            check($sformatf("%s sp%0d busy", tag, i), 32'(o_busy),     32'd1);
            check($sformatf("%s sp%0d cmpl", tag, i), 32'(o_complete), 32'd0);
         end else begin
            check({tag, " end cmpl"},  32'(o_complete), 32'd1);
            check({tag, " end busy"},  32'(o_busy),     32'd0);
            check({tag, " end bit"},   32'(o_bit),      32'd1);
            check({tag, " end cnt"},   32'(o_cnt),      32'(len - 1));
            check({tag, " end bytes"}, 32'(o_bytes),    32'(bytes));
         end
      end
      // Hold in COMPLETE with a live start condition and five more strobes
      rtr_complete = 1'b1;
      for (int h = 0; h < 5; h++) begin
         sample_point = 1'b1;
         tick();
         sample_point = 1'b0;
         tick();
         check($sformatf("%s hold%0d cmpl", tag, h), 32'(o_complete), 32'd1);
         check($sformatf("%s hold%0d cnt", tag, h),  32'(o_cnt),      32'(len - 1));
         check($sformatf("%s hold%0d busy", tag, h), 32'(o_busy),     32'd0);
         check($sformatf("%s hold%0d bytes", tag, h), 32'(o_bytes),   32'(bytes));
      end
      tx_request = 1'b0;
      rtr_complete = 1'b0;
      tick();
      check_idle({tag, " release"});
   endtask

   typedef struct {
      logic       sel;
      logic       ide, rtr, fdf, brs, esi;
      logic [3:0] dlc;
      int         len;
      logic [8:0] bits;
      int         bytes;
      int         brs_at;
   } vec_t;

   vec_t tbl [10];

   initial begin
      int m_len, m_bytes, m_brs_at;
      logic [8:0] m_vec;
      logic r_sel, r_ide, r_rtr, r_fdf, r_brs, r_esi;
      logic [3:0] r_dlc;

      //           sel   ide   rtr   fdf   brs   esi   dlc    len bits          bytes brs_at
      tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4,  6, 9'b000100_000,  4, -1};
      tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd12, 6, 9'b001100_000,  8, -1};
      tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd13, 9, 9'b010101101,  32,  3};
      tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd15, 6, 9'b001111_000,  0, -1};
      tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd9,  8, 9'b10111001_0, 12,  2};
      tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd8,  9, 9'b010011000,   8, -1};
      tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd15, 6, 9'b001111_000,  8, -1};
      tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  8, 9'b10000000_0,  0, -1};
      tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd13, 6, 9'b001101_000,  8, -1};
      tbl[9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd5,  6, 9'b000101_000,  5, -1};

      reset_n = 1'b0;
      enable = 1'b0; sample_point = 1'b0; tx_request = 1'b0; rtr_complete = 1'b0;
      ide = 1'b0; rtr = 1'b0; fdf = 1'b0; brs = 1'b0; esi = 1'b0; dlc = 4'd0;
      tick(); tick(); tick();
      dut_sel = 1'b0; #1;
      check_idle("reset fd");
      dut_sel = 1'b1; #1;
      check_idle("reset cl");
      #3 reset_n = 1'b1;
      tick();

      // Directed vectors
      for (int t = 0; t < 10; t++) begin
         run_frame(tbl[t].sel, tbl[t].ide, tbl[t].rtr, tbl[t].fdf, tbl[t].brs,
                   tbl[t].esi, tbl[t].dlc, tbl[t].len, tbl[t].bits, tbl[t].bytes,
                   tbl[t].brs_at, (t % 2) == 1);
      end

      // Abort by enable after three strobes of an FD base frame
      dut_sel = 1'b0;
      ide = 1'b0; rtr = 1'b0; fdf = 1'b1; brs = 1'b1; esi = 1'b0; dlc = 4'd13;
      enable = 1'b1; tx_request = 1'b1; rtr_complete = 1'b1;
      tick();
      rtr_complete = 1'b0;
      for (int k = 0; k < 3; k++) begin
         sample_point = 1'b1; tick();
         sample_point = 1'b0; tick();
      end
      check("abort pre cnt", 32'(o_cnt), 32'd3);
      enable = 1'b0;
      tick();
      check_idle("abort en");
      for (int k = 0; k < 3; k++) begin
         sample_point = 1'b1; tick();
         check("abort en stays", 32'(o_complete), 32'd0);
      end
      sample_point = 1'b0;
      run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 6, 9'b000010_000, 2, -1, 1'b0);

      // Abort by Tx_request, restart on the very next cycle
      ide = 1'b1; rtr = 1'b0; fdf = 1'b1; brs = 1'b1; esi = 1'b1; dlc = 4'd7;
      enable = 1'b1; tx_request = 1'b1; rtr_complete = 1'b1;
      tick();
      rtr_complete = 1'b0;
      sample_point = 1'b1; tick();
      sample_point = 1'b0;
      tx_request = 1'b0;
      tick();
      check_idle("abort tx");
      run_frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd9, 6, 9'b001001_000, 8, -1, 1'b0);

      // Asynchronous reset in the middle of a field
      ide = 1'b0; rtr = 1'b0; fdf = 1'b1; brs = 1'b0; esi = 1'b1; dlc = 4'd11;
      enable = 1'b1; tx_request = 1'b1; rtr_complete = 1'b1;
      tick();
      rtr_complete = 1'b0;
      sample_point = 1'b1; tick(); tick();
      sample_point = 1'b0;
      check("areset pre busy", 32'(o_busy), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check_idle("areset");
      tx_request = 1'b0;
      tick();
      #2 reset_n = 1'b1;
      tick();
      check_idle("areset rel");

      // Random frames against the reference model, both instances
      for (int r = 0; r < 40; r++) begin
         r_sel = 1'($urandom); r_ide = 1'($urandom); r_rtr = ($urandom_range(0, 5) == 0);
         r_fdf = 1'($urandom); r_brs = 1'($urandom); r_esi = 1'($urandom);
         r_dlc = 4'($urandom);
         model(!r_sel, r_ide, r_rtr, r_fdf, r_brs, r_esi, r_dlc, m_len, m_vec, m_bytes, m_brs_at);
         run_frame(r_sel, r_ide, r_rtr, r_fdf, r_brs, r_esi, r_dlc, m_len, m_vec,
                   m_bytes, m_brs_at, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
